// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and mtime behind a valid/ready register port.
// Define CLINT_MTIME_WR_EN to make mtime writable; otherwise mtime writes are dropped.
module clint #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wmask,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              extint_software,
    output logic              extint_timer,
    output logic [63:0]       mtime_out
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_W-1:0] OFF_MSIP = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_CMP  = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_TIME = ADDR_W'(16'hBFF8);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic              msip;
    logic [63:0]       mtimecmp;
    logic [63:0]       mtime;
    logic [PW-1:0]     presc;
    logic              accept;
    logic              tick;
    logic [ADDR_W-1:0] addr_word;
    logic              hit_msip;
    logic              hit_cmp;
    logic              hit_time;
    logic [63:0]       wmask64;
    logic [63:0]       rd_data;
    logic              rd_err;
    logic              msip_wr;
    logic [63:0]       cmp_wr;
`ifdef CLINT_MTIME_WR_EN
    logic [63:0]       time_wr;
`endif

    assign rst_n     = rst_sync[1];
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;
    assign mtime_out = mtime;
    assign addr_word = req_addr & ~ADDR_W'(7);

    // Reset asserts asynchronously, deasserts after two clk edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_comb begin
        tick = 1'b1;
        if (TICK_DIV > 1) begin
            tick = (presc == PW'(TICK_DIV - 1));
        end
    end

    // Address decode, read mux and byte-merged write values
    always_comb begin
        wmask64 = '0;
        rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            wmask64[8*i +: 8] = {8{req_wmask[i]}};
        end
        hit_msip = (addr_word == OFF_MSIP);
        hit_cmp  = (addr_word == OFF_CMP);
        hit_time = (addr_word == OFF_TIME);
        rd_err   = !(hit_msip || hit_cmp || hit_time);
        if (!req_wen) begin
            if (hit_msip) begin
                rd_data = {63'd0, msip};
            end else if (hit_cmp) begin
                rd_data = mtimecmp;
            end else if (hit_time) begin
                rd_data = mtime;
            end
        end
        msip_wr = req_wmask[0] ? req_wdata[0] : msip;
        cmp_wr  = (mtimecmp & ~wmask64) | (req_wdata & wmask64);
`ifdef CLINT_MTIME_WR_EN
        time_wr = (mtime & ~wmask64) | (req_wdata & wmask64);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (TICK_DIV > 1) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // Architectural registers; an mtime write beats a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
            mtime    <= '0;
        end else begin
            if (accept && req_wen && hit_msip) begin
                msip <= msip_wr;
            end
            if (accept && req_wen && hit_cmp) begin
                mtimecmp <= cmp_wr;
            end
`ifdef CLINT_MTIME_WR_EN
            if (accept && req_wen && hit_time) begin
                mtime <= time_wr;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
`else
            if (tick) begin
                mtime <= mtime + 64'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= rd_data;
            resp_err   <= rd_err;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extint_software <= 1'b0;
            extint_timer    <= 1'b0;
        end else begin
            extint_software <= msip;
            extint_timer    <= (mtime >= mtimecmp);
        end
    end

endmodule
